// File: rtl/alu_op_sequencer.sv
// Sequencer in front of the 32-bit combinational ALU: takes one request at a time, holds the
// ALU inputs for SETTLE cycles, captures the result and returns it over a backpressured handshake.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request; alu_ctr parked at 000
// EXEC  | ALU inputs held; settle counter runs down to capture
// RESP  | response presented on rsp_*, waiting for rsp_ready
module alu_op_sequencer #(
    parameter int N      = 32,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_func_i,
    input  logic [N-1:0]     req_a_i,
    input  logic [N-1:0]     req_b_i,
    output logic [N-1:0]     alu_a_o,
    output logic [N-1:0]     alu_b_o,
    output logic [2:0]       alu_ctr_o,
    input  logic [N-1:0]     alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [N-1:0]     rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_overflow_o,
    output logic             rsp_illegal_o,
    output logic             ov_sticky_o,
    input  logic             ov_clear_i,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       ctr_q, ctr_d;
    logic [N-1:0]     rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ov_q, rsp_ov_d;
    logic             rsp_ill_q, rsp_ill_d;
    logic             ov_sticky_q, ov_sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             func_legal;
    logic [2:0]       func_ctr;
    logic             ov_masked;

    always_comb begin
        func_legal = 1'b1;
        func_ctr   = 3'b000;
        case (req_func_i)
            4'd0:    func_ctr = 3'b000;
            4'd1:    func_ctr = 3'b001;
            4'd2:    func_ctr = 3'b010;
            4'd3:    func_ctr = 3'b100;
            4'd4:    func_ctr = 3'b101;
            4'd5:    func_ctr = 3'b110;
            4'd6:    func_ctr = 3'b111;
            default: func_legal = 1'b0;
        endcase
    end

    // Only the signed ADD (001) and SUB (101) encodings report overflow.
    assign ov_masked = alu_overflow_i & ctr_q[0] & ~ctr_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        ctr_d        = ctr_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ov_d     = rsp_ov_q;
        rsp_ill_d    = rsp_ill_q;
        ov_sticky_d  = ov_sticky_q & ~ov_clear_i;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (func_legal) begin
                        alu_a_d = req_a_i;
                        alu_b_d = req_b_i;
                        ctr_d   = func_ctr;
                        cnt_d   = SETTLE_L;
                        state_d = EXEC;
                    end else begin
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_ov_d     = 1'b0;
                        rsp_ill_d    = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_result_d = alu_result_i;
                    rsp_zero_d   = alu_zero_i;
                    rsp_ov_d     = ov_masked;
                    rsp_ill_d    = 1'b0;
                    if (ov_masked) ov_sticky_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    ctr_d   = 3'b000;
                    state_d = IDLE;
                    if (!rsp_ill_q) op_count_d = op_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            ctr_q        <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ov_q     <= 1'b0;
            rsp_ill_q    <= 1'b0;
            ov_sticky_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            ctr_q        <= ctr_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ov_q     <= rsp_ov_d;
            rsp_ill_q    <= rsp_ill_d;
            ov_sticky_q  <= ov_sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_ctr_o      = ctr_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_zero_o     = rsp_zero_q;
    assign rsp_overflow_o = rsp_ov_q;
    assign rsp_illegal_o  = rsp_ill_q;
    assign ov_sticky_o    = ov_sticky_q;
    assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (default, and SETTLE=3/CNT_W=4), each driving a
// behavioural ALU, checked against constant vectors and an arithmetic reference model.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic [3:0]  req_func  [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic        rsp_ready [2];
    logic        ov_clear  [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_zero  [2];
    logic        rsp_ov    [2];
    logic        rsp_ill   [2];
    logic        ov_sticky [2];
    logic [31:0] alu_a     [2];
    logic [31:0] alu_b     [2];
    logic [31:0] rsp_result[2];
    logic [2:0]  alu_ctr   [2];
    logic [33:0] alu_out   [2];
    logic [15:0] op_count0;
    logic [3:0]  op_count1;

    int   cnt_m   [2];
    logic stick_m [2];

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    // Stand-in for the team ALU: {overflow, zero, result}; overflow is raw signed overflow
    // for every add/sub encoding so the sequencer's masking is exercised.
    function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov;
        s = '0; r = '0; ov = 1'b0;
        case (c)
            3'b000, 3'b001: begin s = {a[31], a} + {b[31], b}; r = s[31:0]; ov = s[32] ^ s[31]; end
            3'b010:         r = a | b;
            3'b100, 3'b101: begin s = {a[31], a} - {b[31], b}; r = s[31:0]; ov = s[32] ^ s[31]; end
            3'b110:         r = {31'd0, a < b};
            3'b111:         r = {31'd0, $signed(a) < $signed(b)};
            default:        r = '0;
        endcase
        return {ov, (r == 32'd0), r};
    endfunction

    assign alu_out[0] = alu_model(alu_a[0], alu_b[0], alu_ctr[0]);
    assign alu_out[1] = alu_model(alu_a[1], alu_b[1], alu_ctr[1]);

    alu_op_sequencer u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_func_i(req_func[0]),
        .req_a_i(req_a[0]), .req_b_i(req_b[0]),
        .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_ctr_o(alu_ctr[0]),
        .alu_result_i(alu_out[0][31:0]), .alu_zero_i(alu_out[0][32]), .alu_overflow_i(alu_out[0][33]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_result_o(rsp_result[0]),
        .rsp_zero_o(rsp_zero[0]), .rsp_overflow_o(rsp_ov[0]), .rsp_illegal_o(rsp_ill[0]),
        .ov_sticky_o(ov_sticky[0]), .ov_clear_i(ov_clear[0]), .op_count_o(op_count0)
    );

    alu_op_sequencer #(.SETTLE(3), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_func_i(req_func[1]),
        .req_a_i(req_a[1]), .req_b_i(req_b[1]),
        .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_ctr_o(alu_ctr[1]),
        .alu_result_i(alu_out[1][31:0]), .alu_zero_i(alu_out[1][32]), .alu_overflow_i(alu_out[1][33]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_result_o(rsp_result[1]),
        .rsp_zero_o(rsp_zero[1]), .rsp_overflow_o(rsp_ov[1]), .rsp_illegal_o(rsp_ill[1]),
        .ov_sticky_o(ov_sticky[1]), .ov_clear_i(ov_clear[1]), .op_count_o(op_count1)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        ov;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        ov;
        logic        ill;
    } vec_t;

    function automatic exp_t ref_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (f)
            4'd0: e.r = a + b;
            4'd1: begin wide = sa + sb; e.r = a + b; e.ov = (wide > MAXS) || (wide < MINS); end
            4'd2: e.r = a | b;
            4'd3: e.r = a - b;
            4'd4: begin wide = sa - sb; e.r = a - b; e.ov = (wide > MAXS) || (wide < MINS); end
            4'd5: e.r = (a < b) ? 32'd1 : 32'd0;
            4'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = !e.ill && (e.r == 32'd0);
        return e;
    endfunction

    function automatic logic [2:0] ctr_of(input logic [3:0] f);
        case (f)
            4'd0: return 3'b000;
            4'd1: return 3'b001;
            4'd2: return 3'b010;
            4'd3: return 3'b100;
            4'd4: return 3'b101;
            4'd5: return 3'b110;
            4'd6: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] act_cnt(input int s);
        return (s == 0) ? op_count0 : {12'd0, op_count1};
    endfunction

    function automatic logic [15:0] exp_cnt(input int s);
        return (s == 0) ? 16'(cnt_m[0] % 65536) : 16'(cnt_m[1] % 16);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following the handshake.
    task automatic do_op(input int s, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic clr, input logic tog,
                         output int lat, output logic [31:0] r, output logic z,
                         output logic ov, output logic ill);
        int guard;
        logic [2:0] ctr_exp;
        guard = 0;
        while (!req_ready[s] && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("req_ready_idle", req_ready[s], 1);
        req_valid[s] = 1'b1; req_func[s] = f; req_a[s] = a; req_b[s] = b; ov_clear[s] = clr;
        ctr_exp = ctr_of(f);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin
                req_valid[s] = 1'b0;
                req_func[s]  = 4'($urandom);
                req_a[s]     = $urandom;
                req_b[s]     = $urandom;
            end
            if (!rsp_valid[s]) begin
                chk("exec_alu_a", alu_a[s], a);
                chk("exec_alu_b", alu_b[s], b);
                chk("exec_alu_ctr", alu_ctr[s], ctr_exp);
                chk("exec_req_ready", req_ready[s], 0);
            end
        end while (!rsp_valid[s] && lat < 40);
        ov_clear[s] = 1'b0;
        chk("rsp_valid_seen", rsp_valid[s], 1);
        if (f > 4'd6) chk("illegal_alu_ctr", alu_ctr[s], 0);
        r = rsp_result[s]; z = rsp_zero[s]; ov = rsp_ov[s]; ill = rsp_ill[s];
        for (int i = 0; i < hold; i++) begin
            if (tog) begin
                req_valid[s] = 1'($urandom);
                req_func[s]  = 4'($urandom);
                req_a[s]     = $urandom;
                req_b[s]     = $urandom;
            end
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid[s], 1);
            chk("bp_rsp_stable", {rsp_result[s], rsp_zero[s], rsp_ov[s], rsp_ill[s]}, {r, z, ov, ill});
            chk("bp_req_ready", req_ready[s], 0);
        end
        if (tog) begin
            req_valid[s] = 1'b1;
            req_func[s]  = 4'd0;
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
        req_valid[s] = 1'b0;
        chk("post_hs_rsp_valid", rsp_valid[s], 0);
        chk("post_hs_req_ready", req_ready[s], 1);
        chk("idle_alu_ctr", alu_ctr[s], 0);
    endtask

    task automatic check_op(input int s, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int hold, input logic clr, input logic tog);
        int lat;
        logic [31:0] r;
        logic z, ov, ill;
        exp_t e;
        do_op(s, f, a, b, hold, clr, tog, lat, r, z, ov, ill);
        e = ref_op(f, a, b);
        if (clr) stick_m[s] = 1'b0;
        if (e.ov) stick_m[s] = 1'b1;
        if (!e.ill) cnt_m[s]++;
        chk("result", r, e.r);
        chk("zero", z, e.z);
        chk("overflow", ov, e.ov);
        chk("illegal", ill, e.ill);
        chk("latency", lat, e.ill ? 1 : 1 + ((s == 0) ? 1 : 3));
        chk("ov_sticky", ov_sticky[s], stick_m[s]);
        chk("op_count", act_cnt(s), exp_cnt(s));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int lat;
        logic [31:0] r;
        logic z, ov, ill;
        logic [3:0] f;

        vecs[0] = '{4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'd3, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'd9, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{4'd4, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};

        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; req_valid[s] = 1'b0; req_func[s] = '0; req_a[s] = '0; req_b[s] = '0;
            rsp_ready[s] = 1'b0; ov_clear[s] = 1'b0; cnt_m[s] = 0; stick_m[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready[0], 1);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_alu_ctr", alu_ctr[0], 0);
        chk("rst_alu_a", alu_a[0], 0);
        chk("rst_rsp_result", rsp_result[0], 0);
        chk("rst_ov_sticky", ov_sticky[0], 0);
        chk("rst_op_count", op_count0, 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Constant vectors on the default instance.
        for (int i = 0; i < 8; i++) begin
            do_op(0, vecs[i].f, vecs[i].a, vecs[i].b, i % 3, 1'b0, 1'b0, lat, r, z, ov, ill);
            if (vecs[i].ov) stick_m[0] = 1'b1;
            if (!vecs[i].ill) cnt_m[0]++;
            chk("vec_result", r, vecs[i].r);
            chk("vec_zero", z, vecs[i].z);
            chk("vec_overflow", ov, vecs[i].ov);
            chk("vec_illegal", ill, vecs[i].ill);
            chk("vec_latency", lat, vecs[i].ill ? 1 : 2);
            chk("vec_ov_sticky", ov_sticky[0], stick_m[0]);
            chk("vec_op_count", op_count0, exp_cnt(0));
        end

        ov_clear[0] = 1'b1;
        @(posedge clk); #1;
        ov_clear[0] = 1'b0;
        stick_m[0] = 1'b0;
        chk("ov_clear_idle", ov_sticky[0], 0);

        // Clear held through the overflow capture: set must win.
        check_op(0, 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b1, 1'b0);
        chk("set_beats_clear", ov_sticky[0], 1);

        // Long backpressure with request lines toggling.
        check_op(0, 4'd2, 32'hA5A5_0000, 32'h0000_5A5A, 10, 1'b0, 1'b1);
        check_op(0, 4'd0, 32'h0000_0005, 32'h0000_0006, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            check_op(0, f, pick_operand(), pick_operand(), $urandom_range(0, 3),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end

        // SETTLE=3 instance: latency, then reset in the middle of EXEC.
        check_op(1, 4'd3, 32'h1234_5678, 32'h1234_5678, 0, 1'b0, 1'b0);
        check_op(1, 4'd0, 32'h0000_0001, 32'h0000_0002, 1, 1'b0, 1'b0);
        req_valid[1] = 1'b1; req_func[1] = 4'd1; req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'h1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_in_exec", req_ready[1], 0);
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready[1], 1);
        chk("mid_rst_rsp_valid", rsp_valid[1], 0);
        chk("mid_rst_alu_a", alu_a[1], 0);
        chk("mid_rst_alu_b", alu_b[1], 0);
        chk("mid_rst_alu_ctr", alu_ctr[1], 0);
        chk("mid_rst_rsp_result", rsp_result[1], 0);
        chk("mid_rst_ov_sticky", ov_sticky[1], 0);
        chk("mid_rst_op_count", op_count1, 0);
        cnt_m[1] = 0; stick_m[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", rsp_valid[1], 0);
        end

        // Counter wrap at CNT_W=4: 15 legal, one illegal, one more legal.
        for (int i = 0; i < 15; i++)
            check_op(1, 4'($urandom_range(0, 6)), pick_operand(), pick_operand(), 0, 1'b0, 1'b0);
        chk("count_at_15", op_count1, 15);
        check_op(1, 4'd12, 32'h1, 32'h2, 0, 1'b0, 1'b0);
        chk("illegal_no_count", op_count1, 15);
        check_op(1, 4'd2, 32'h1, 32'h2, 0, 1'b0, 1'b0);
        chk("count_wrap", op_count1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
